// File: rtl/vram_arbiter.sv
// VRAM port arbiter: scanout owns the read port, renderer/CPU share the write port round-robin with bounded bursts.
// Writes land 1 cycle after grant, reads return RD_LAT cycles after grant; optional stall counters under VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rend_req,
  input  logic [18:0] rend_addr,
  input  logic        rend_data,
  output logic        rend_gnt,
  input  logic        cpu_wreq,
  input  logic [18:0] cpu_waddr,
  input  logic        cpu_wdata,
  output logic        cpu_wgnt,
  input  logic        cpu_rreq,
  input  logic [18:0] cpu_raddr,
  output logic        cpu_rgnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        scan_req,
  input  logic [18:0] scan_addr,
  output logic        scan_valid,
  output logic [15:0] scan_data,
  output logic        vram_we,
  output logic [18:0] vram_waddr,
  output logic        vram_wdata,
  output logic [18:0] vram_raddr,
  input  logic [15:0] vram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0] rend_stall_cnt,
  output logic [15:0] cpu_wstall_cnt,
  output logic [15:0] cpu_rstall_cnt
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_REND, W_CPU} wstate_t;

  localparam logic [7:0] MB = 8'(MAX_BURST);

  wstate_t     state, state_nxt;
  logic        last_cpu, last_cpu_nxt;
  logic [7:0]  burst_cnt, burst_cnt_nxt, burst_inc;
  logic        own_rend, own_cpu;

  assign burst_inc = (burst_cnt == 8'hFF) ? 8'hFF : burst_cnt + 8'd1;

  always_comb begin
    own_rend      = 1'b0;
    own_cpu       = 1'b0;
    state_nxt     = W_IDLE;
    burst_cnt_nxt = burst_cnt;
    last_cpu_nxt  = last_cpu;
    if (state == W_REND && rend_req && (!cpu_wreq || burst_cnt < MB)) begin
      own_rend = 1'b1;
    end else if (state == W_CPU && cpu_wreq && (!rend_req || burst_cnt < MB)) begin
      own_cpu = 1'b1;
    end else if (rend_req && cpu_wreq) begin
      own_rend = last_cpu;
      own_cpu  = !last_cpu;
    end else begin
      own_rend = rend_req;
      own_cpu  = cpu_wreq;
    end
    if (own_rend) begin
      state_nxt     = W_REND;
      last_cpu_nxt  = 1'b0;
      burst_cnt_nxt = (state == W_REND) ? burst_inc : 8'd1;
    end else if (own_cpu) begin
      state_nxt     = W_CPU;
      last_cpu_nxt  = 1'b1;
      burst_cnt_nxt = (state == W_CPU) ? burst_inc : 8'd1;
    end
  end

  // Grants are masked in reset so a beat presented then is simply dropped.
  assign rend_gnt = rst_n & own_rend;
  assign cpu_wgnt = rst_n & own_cpu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= W_IDLE;
      last_cpu  <= 1'b1;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      last_cpu  <= last_cpu_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  logic        we_q;
  logic [18:0] waddr_q;
  logic        wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 1'b0;
    end else begin
      we_q <= rend_gnt | cpu_wgnt;
      if (rend_gnt) begin
        waddr_q <= rend_addr;
        wdata_q <= rend_data;
      end else if (cpu_wgnt) begin
        waddr_q <= cpu_waddr;
        wdata_q <= cpu_wdata;
      end
    end
  end

  assign vram_we    = rst_n & we_q;
  assign vram_waddr = rst_n ? waddr_q : '0;
  assign vram_wdata = rst_n & wdata_q;

  logic        scan_rd;
  logic [18:0] raddr_q;
  logic [1:0]  tag_pipe [RD_LAT];
  logic [1:0]  tag_out;
  logic [15:0] sdata_q, cdata_q;

  assign scan_rd  = rst_n & scan_req;
  assign cpu_rgnt = rst_n & cpu_rreq & ~scan_req;

  always_comb begin
    vram_raddr = raddr_q;
    if (!rst_n)        vram_raddr = '0;
    else if (scan_req) vram_raddr = scan_addr;
    else if (cpu_rreq) vram_raddr = cpu_raddr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr_q <= '0;
      sdata_q <= '0;
      cdata_q <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_pipe[k] <= 2'b00;
    end else begin
      if (scan_rd || cpu_rgnt) raddr_q <= vram_raddr;
      sdata_q     <= scan_data;
      cdata_q     <= cpu_rdata;
      tag_pipe[0] <= {scan_rd, cpu_rgnt};
      for (int k = 1; k < RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Tag {scan, cpu} emerges aligned with the VRAM's returned word.
  assign tag_out    = tag_pipe[RD_LAT-1];
  assign scan_valid = rst_n & tag_out[1];
  assign cpu_rvalid = rst_n & tag_out[0];
  assign scan_data  = !rst_n ? 16'h0000 : (scan_valid ? vram_rdata : sdata_q);
  assign cpu_rdata  = !rst_n ? 16'h0000 : (cpu_rvalid ? vram_rdata : cdata_q);

`ifdef VRAM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rend_stall_cnt <= '0;
      cpu_wstall_cnt <= '0;
      cpu_rstall_cnt <= '0;
    end else begin
      if (rend_req && !rend_gnt) rend_stall_cnt <= sat_inc16(rend_stall_cnt);
      if (cpu_wreq && !cpu_wgnt) cpu_wstall_cnt <= sat_inc16(cpu_wstall_cnt);
      if (cpu_rreq && !cpu_rgnt) cpu_rstall_cnt <= sat_inc16(cpu_rstall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: queue/ownership reference model compared every cycle plus literal spot checks.
module tb_vram_arbiter;
  localparam int MB = 8;
  localparam int RL = 1;

  logic        clk, rst_n;
  logic        rend_req, rend_data, rend_gnt;
  logic [18:0] rend_addr;
  logic        cpu_wreq, cpu_wdata, cpu_wgnt;
  logic [18:0] cpu_waddr;
  logic        cpu_rreq, cpu_rgnt, cpu_rvalid;
  logic [18:0] cpu_raddr;
  logic [15:0] cpu_rdata;
  logic        scan_req, scan_valid;
  logic [18:0] scan_addr;
  logic [15:0] scan_data;
  logic        vram_we, vram_wdata;
  logic [18:0] vram_waddr, vram_raddr;
  logic [15:0] vram_rdata;

  vram_arbiter #(.MAX_BURST(MB), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .rend_req(rend_req), .rend_addr(rend_addr), .rend_data(rend_data), .rend_gnt(rend_gnt),
    .cpu_wreq(cpu_wreq), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wgnt(cpu_wgnt),
    .cpu_rreq(cpu_rreq), .cpu_raddr(cpu_raddr), .cpu_rgnt(cpu_rgnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_data(scan_data),
    .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
    .vram_raddr(vram_raddr), .vram_rdata(vram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  // VRAM contents are a fixed function of the address, so returned words identify their request.
  function automatic logic [15:0] vfun(input logic [18:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  logic [18:0] hist [RL];
  logic [18:0] cap;
  initial begin
    vram_rdata = '0;
    for (int k = 0; k < RL; k++) hist[k] = '0;
    forever begin
      @(negedge clk);
      cap = vram_raddr;
      @(posedge clk);
      #1;
      for (int k = RL - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0]    = cap;
      vram_rdata = vfun(hist[RL-1]);
    end
  end

  // Reference model: ownership history for writes, a queue of outstanding reads for returns.
  typedef struct {int due; bit scan; logic [18:0] addr;} rd_t;
  rd_t         pend[$];
  rd_t         r;
  int          cyc = 0;
  int          own, m_prev, m_run, m_last;
  bit          m_we, e_cr, e_sv, e_cv;
  logic [18:0] m_waddr, m_raddr;
  logic        m_wdata;
  logic [15:0] m_sdata, m_cdata;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("m_rend_gnt", rend_gnt, 0);
      chk("m_cpu_wgnt", cpu_wgnt, 0);
      chk("m_cpu_rgnt", cpu_rgnt, 0);
      chk("m_scan_valid", scan_valid, 0);
      chk("m_cpu_rvalid", cpu_rvalid, 0);
      chk("m_vram_we", vram_we, 0);
      chk("m_vram_waddr", vram_waddr, 0);
      chk("m_vram_wdata", vram_wdata, 0);
      chk("m_vram_raddr", vram_raddr, 0);
      chk("m_scan_data", scan_data, 0);
      chk("m_cpu_rdata", cpu_rdata, 0);
      m_prev = 0; m_run = 0; m_last = 2; m_we = 0;
      m_waddr = '0; m_wdata = 1'b0; m_raddr = '0; m_sdata = '0; m_cdata = '0;
      pend.delete();
    end else begin
      e_sv = 0; e_cv = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.scan) begin e_sv = 1; m_sdata = vfun(r.addr); end
        else begin e_cv = 1; m_cdata = vfun(r.addr); end
      end
      if (m_prev == 1 && rend_req && (!cpu_wreq || m_run < MB)) own = 1;
      else if (m_prev == 2 && cpu_wreq && (!rend_req || m_run < MB)) own = 2;
      else if (rend_req && !cpu_wreq) own = 1;
      else if (cpu_wreq && !rend_req) own = 2;
      else if (rend_req && cpu_wreq) own = (m_last == 1) ? 2 : 1;
      else own = 0;
      e_cr = 0;
      if (scan_req) begin
        m_raddr = scan_addr;
        pend.push_back('{cyc + RL, 1'b1, scan_addr});
      end else if (cpu_rreq) begin
        e_cr = 1;
        m_raddr = cpu_raddr;
        pend.push_back('{cyc + RL, 1'b0, cpu_raddr});
      end
      chk("m_rend_gnt", rend_gnt, own == 1);
      chk("m_cpu_wgnt", cpu_wgnt, own == 2);
      chk("m_cpu_rgnt", cpu_rgnt, e_cr);
      chk("m_scan_valid", scan_valid, e_sv);
      chk("m_cpu_rvalid", cpu_rvalid, e_cv);
      chk("m_scan_data", scan_data, m_sdata);
      chk("m_cpu_rdata", cpu_rdata, m_cdata);
      chk("m_vram_raddr", vram_raddr, m_raddr);
      chk("m_vram_we", vram_we, m_we);
      if (m_we) begin
        chk("m_vram_waddr", vram_waddr, m_waddr);
        chk("m_vram_wdata", vram_wdata, m_wdata);
      end
      m_we = (own != 0);
      if (own == 1) begin m_waddr = rend_addr; m_wdata = rend_data; end
      if (own == 2) begin m_waddr = cpu_waddr; m_wdata = cpu_wdata; end
      if (own != 0) begin
        m_run  = (own == m_prev) ? m_run + 1 : 1;
        m_last = own;
        m_prev = own;
      end else begin
        m_prev = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    rend_req = 0; cpu_wreq = 0; cpu_rreq = 0; scan_req = 0;
  endtask

  int ns, nc;
  bit exp_r;

  initial begin
    rst_n = 0;
    rend_req = 1; rend_addr = 19'd5; rend_data = 1;
    cpu_wreq = 0; cpu_waddr = '0; cpu_wdata = 0;
    cpu_rreq = 1; cpu_raddr = 19'd9;
    scan_req = 1; scan_addr = 19'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rend_gnt", rend_gnt, 0);
    chk("rst_cpu_rgnt", cpu_rgnt, 0);
    chk("rst_vram_raddr", vram_raddr, 0);
    chk("rst_vram_we", vram_we, 0);

    step(); rst_n = 1; idle_all();

    // renderer alone, 20 beats
    for (int i = 0; i < 20; i++) begin
      step();
      rend_req = 1; rend_addr = 19'(i); rend_data = 1;
      @(negedge clk);
      chk("t1_rend_gnt", rend_gnt, 1);
      chk("t1_cpu_wgnt", cpu_wgnt, 0);
      if (i > 0) chk("t1_waddr", vram_waddr, i - 1);
    end
    step(); rend_req = 0;
    @(negedge clk);
    chk("t1_last_we", vram_we, 1);
    chk("t1_last_waddr", vram_waddr, 19);

    // tie from idle with renderer as last owner
    step();
    rend_req = 1; rend_addr = 19'd200; rend_data = 0;
    cpu_wreq = 1; cpu_waddr = 19'd100; cpu_wdata = 1;
    @(negedge clk);
    chk("t3_cpu_first", cpu_wgnt, 1);
    chk("t3_rend_wait", rend_gnt, 0);
    step(); idle_all();

    // both writers from the first cycle after reset
    step(); rst_n = 0;
    step(); rst_n = 1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) step();
      rend_req = 1; rend_addr = 19'(300 + k); rend_data = k[0];
      cpu_wreq = 1; cpu_waddr = 19'(400 + k); cpu_wdata = ~k[1];
      @(negedge clk);
      exp_r = ((k / 8) % 2) == 0;
      chk("t2_rend_gnt", rend_gnt, exp_r);
      chk("t2_cpu_wgnt", cpu_wgnt, !exp_r);
    end
    step(); idle_all();

    // scanout starves CPU read for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      scan_req = 1; scan_addr = 19'(1000 + i);
      cpu_rreq = 1; cpu_raddr = 19'h05A7C;
      @(negedge clk);
      chk("t4_cpu_rgnt_starved", cpu_rgnt, 0);
      if (i > 0) chk("t4_scan_valid", scan_valid, 1);
    end
    step(); scan_req = 0;
    @(negedge clk);
    chk("t4_cpu_rgnt", cpu_rgnt, 1);
    chk("t4_scan_data", scan_data, 16'hA632);
    step(); cpu_rreq = 0;
    @(negedge clk);
    chk("t4_cpu_rvalid", cpu_rvalid, 1);
    chk("t4_cpu_rdata", cpu_rdata, 16'hFFBF);
    chk("t4_scan_valid_off", scan_valid, 0);

    // alternating scan / CPU reads
    ns = 0; nc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      scan_req = (i % 2 == 0); scan_addr = 19'(2000 + i);
      cpu_rreq = (i % 2 == 1); cpu_raddr = 19'(3000 + i);
      @(negedge clk);
      if (i > 0) chk("t5_scan_valid", scan_valid, i % 2 == 1);
      ns += int'(scan_valid); nc += int'(cpu_rvalid);
    end
    step(); idle_all();
    @(negedge clk);
    ns += int'(scan_valid); nc += int'(cpu_rvalid);
    chk("t5_scan_count", ns, 6);
    chk("t5_cpu_count", nc, 6);

    // reset with a CPU read in flight and the renderer requesting
    step();
    cpu_rreq = 1; cpu_raddr = 19'd42;
    rend_req = 1; rend_addr = 19'd500; rend_data = 1;
    @(negedge clk);
    chk("t6_cpu_rgnt", cpu_rgnt, 1);
    chk("t6_rend_gnt", rend_gnt, 1);
    step(); rst_n = 0; cpu_rreq = 0; rend_addr = 19'd501;
    @(negedge clk);
    chk("t6_flushed_rvalid", cpu_rvalid, 0);
    chk("t6_rst_we", vram_we, 0);
    chk("t6_rst_rend_gnt", rend_gnt, 0);
    step(); rst_n = 1; rend_addr = 19'd502;
    @(negedge clk);
    chk("t6_regrant", rend_gnt, 1);
    chk("t6_no_rvalid", cpu_rvalid, 0);
    chk("t6_we_dropped", vram_we, 0);
    step(); rend_req = 0;
    @(negedge clk);
    chk("t6_we", vram_we, 1);
    chk("t6_waddr", vram_waddr, 502);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
